accel_spi_responder: RTL and testbench

//  Synthesizable ADXL345-style 3-wire SPI responder; the sensor end of the accelerometer link.

---
 rtl/accel_spi_responder.sv | 214 +++++++++++++++++++++
 tb/tb_accel_spi_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_responder.sv
// accel_spi_responder
//   Sensor-side ADXL345-style 3-wire SPI responder (mode 3) serving a small register file.
//   Axis data is taken from a sample port; samples arriving during a transaction are held in a
//   one-deep pending buffer and applied on CS_N rise so a burst never returns torn data.
// Ports
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   spi_cs_n       chip select, active-low (asynchronous)
//   spi_sclk       SPI clock, idles high (asynchronous)
//   spi_sdio_in    SDIO pad input
//   spi_sdio_out   SDIO drive value (registered)
//   spi_sdio_oe    SDIO output enable (registered)
//   spi_int        DATA_READY interrupt, polarity set by INT_ACT_HI (registered)
//   sample_x/y/z   16-bit two's-complement axis samples
//   sample_valid   one-cycle strobe qualifying sample_x/y/z
module accel_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID       = 8'hE5,
    parameter bit          INT_ACT_HI  = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_sdio_in,
    output logic        spi_sdio_out,
    output logic        spi_sdio_oe,
    output logic        spi_int,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid
);

    typedef enum logic [2:0] {StIdle, StCmd, StRd, StWr, StDone} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdio_sync_q;
    logic cs_prev_q, sclk_prev_q;
    logic cs_s, sclk_s, sdio_s;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall;

    state_e      state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  tx_q;
    logic [5:0]  addr_q;
    logic        mb_q;
    logic        rd37_q;       // current read transaction has completed a byte at 0x37
    logic [23:0] ofs_q;
    logic [7:0]  bw_rate_q, power_ctl_q, int_enable_q, data_format_q;
    logic [47:0] data_q;       // {Z, Y, X}, byte 0 = DATAX0
    logic [47:0] pend_q;
    logic        pend_valid_q;
    logic        data_ready_q;

    logic [7:0] in_byte;
    logic [5:0] next_addr;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign in_byte   = {shift_q, sdio_s};
    assign next_addr = addr_q + 6'd1;   // wraps 0x3F -> 0x00

    function automatic logic [7:0] reg_read(input logic [5:0] a);
        case (a)
            6'h00:   return DEVID;
            6'h1E:   return ofs_q[7:0];
            6'h1F:   return ofs_q[15:8];
            6'h20:   return ofs_q[23:16];
            6'h2C:   return bw_rate_q;
            6'h2D:   return power_ctl_q;
            6'h2E:   return int_enable_q;
            6'h30:   return {data_ready_q, 7'b0};
            6'h31:   return data_format_q;
            6'h32:   return data_q[7:0];
            6'h33:   return data_q[15:8];
            6'h34:   return data_q[23:16];
            6'h35:   return data_q[31:24];
            6'h36:   return data_q[39:32];
            6'h37:   return data_q[47:40];
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cs_sync_q     <= '1;
            sclk_sync_q   <= '1;
            sdio_sync_q   <= '0;
            cs_prev_q     <= 1'b1;
            sclk_prev_q   <= 1'b1;
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            addr_q        <= '0;
            mb_q          <= 1'b0;
            rd37_q        <= 1'b0;
            ofs_q         <= '0;
            bw_rate_q     <= 8'h0A;
            power_ctl_q   <= '0;
            int_enable_q  <= '0;
            data_format_q <= '0;
            data_q        <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            data_ready_q  <= 1'b0;
            spi_sdio_out  <= 1'b0;
            spi_sdio_oe   <= 1'b0;
            spi_int       <= ~INT_ACT_HI;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], spi_sdio_in};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;

            if (cs_rise) begin
                state_q     <= StIdle;
                bit_cnt_q   <= '0;
                spi_sdio_oe <= 1'b0;
                rd37_q      <= 1'b0;
                if (rd37_q) data_ready_q <= 1'b0;
                // Later assignment: a pending apply beats the read clear.
                if (pend_valid_q) begin
                    data_q       <= pend_q;
                    data_ready_q <= 1'b1;
                    pend_valid_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q   <= StCmd;
                            bit_cnt_q <= '0;
                        end
                    end
                    StCmd: begin
                        if (sclk_rise) begin
                            shift_q   <= in_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                mb_q    <= in_byte[6];
                                addr_q  <= in_byte[5:0];
                                tx_q    <= reg_read(in_byte[5:0]);
                                state_q <= in_byte[7] ? StRd : StWr;
                            end
                        end
                    end
                    StRd: begin
                        if (sclk_fall) begin
                            spi_sdio_out <= tx_q[7];
                            spi_sdio_oe  <= 1'b1;
                            tx_q         <= {tx_q[6:0], 1'b0};
                        end else if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (addr_q == 6'h37) rd37_q <= 1'b1;
                                if (mb_q) begin
                                    addr_q <= next_addr;
                                    tx_q   <= reg_read(next_addr);
                                end else begin
                                    state_q     <= StDone;
                                    spi_sdio_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    StWr: begin
                        if (sclk_rise) begin
                            shift_q   <= in_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                case (addr_q)
                                    6'h1E:   ofs_q[7:0]    <= in_byte;
                                    6'h1F:   ofs_q[15:8]   <= in_byte;
                                    6'h20:   ofs_q[23:16]  <= in_byte;
                                    6'h2C:   bw_rate_q     <= in_byte;
                                    6'h2D:   power_ctl_q   <= in_byte;
                                    6'h2E:   int_enable_q  <= in_byte;
                                    6'h31:   data_format_q <= in_byte;
                                    default: ;
                                endcase
                                if (mb_q) addr_q <= next_addr;
                                else      state_q <= StDone;
                            end
                        end
                    end
                    default: spi_sdio_oe <= 1'b0;   // StDone: SCLK ignored
                endcase
            end

            if (sample_valid) begin
                if (cs_s) begin
                    data_q       <= {sample_z, sample_y, sample_x};
                    data_ready_q <= 1'b1;
                    pend_valid_q <= 1'b0;
                end else begin
                    pend_q       <= {sample_z, sample_y, sample_x};
                    pend_valid_q <= 1'b1;
                end
            end

            spi_int <= INT_ACT_HI ? (int_enable_q[7] & data_ready_q)
                                  : ~(int_enable_q[7] & data_ready_q);
        end
    end

endmodule

// File: tb/tb_accel_spi_responder.sv
module tb_accel_spi_responder;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_sdio_in;
    logic        spi_sdio_out;
    logic        spi_sdio_oe;
    logic        spi_int;
    logic [15:0] sample_x, sample_y, sample_z;
    logic        sample_valid;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: register contents by address plus transaction bookkeeping.
    logic [7:0]  m_regs [64];
    logic        m_ready, m_pend_v;
    logic [47:0] m_pend;
    logic        m_rw, m_mb, m_act, m_hit;
    logic [5:0]  m_addr;

    accel_spi_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .spi_cs_n      (spi_cs_n),
        .spi_sclk      (spi_sclk),
        .spi_sdio_in   (spi_sdio_in),
        .spi_sdio_out  (spi_sdio_out),
        .spi_sdio_oe   (spi_sdio_oe),
        .spi_int       (spi_int),
        .sample_x      (sample_x),
        .sample_y      (sample_y),
        .sample_z      (sample_z),
        .sample_valid  (sample_valid)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_regs[6'h2C] = 8'h0A;
        m_ready  = 1'b0;
        m_pend_v = 1'b0;
        m_pend   = '0;
        m_act    = 1'b0;
        m_hit    = 1'b0;
    endfunction

    function automatic logic [7:0] m_read(input logic [5:0] a);
        if (a == 6'h00) return 8'hE5;
        if (a == 6'h30) return {m_ready, 7'b0};
        if (a == 6'h1E || a == 6'h1F || a == 6'h20 || a == 6'h2C || a == 6'h2D ||
            a == 6'h2E || a == 6'h31 || (a >= 6'h32 && a <= 6'h37)) return m_regs[a];
        return 8'h00;
    endfunction

    function automatic void m_write(input logic [5:0] a, input logic [7:0] v);
        if (a == 6'h1E || a == 6'h1F || a == 6'h20 || a == 6'h2C || a == 6'h2D ||
            a == 6'h2E || a == 6'h31) m_regs[a] = v;
    endfunction

    function automatic void m_load(input logic [47:0] v);
        for (int i = 0; i < 6; i++) m_regs[6'h32 + i] = v[8*i +: 8];
        m_ready = 1'b1;
    endfunction

    function automatic logic exp_int();
        return m_regs[6'h2E][7] & m_ready;
    endfunction

    // Shift n bits of tx MSB first; rx/oem capture the pad just before each rising edge.
    task automatic xfer_bits(input logic [7:0] tx, input int n,
                             output logic [7:0] rx, output logic [7:0] oem);
        rx  = '0;
        oem = '0;
        for (int i = 0; i < n; i++) begin
            spi_sclk    = 1'b0;
            spi_sdio_in = tx[7-i];
            wait_clk(6);
            rx[7-i]  = spi_sdio_out;
            oem[7-i] = spi_sdio_oe;
            spi_sclk = 1'b1;
            wait_clk(6);
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        m_hit    = 1'b0;
        m_act    = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(3);
        check_eq("oe_after_cs_rise", spi_sdio_oe, 1'b0);
        wait_clk(4);
        if (m_hit) m_ready = 1'b0;
        if (m_pend_v) begin
            m_load(m_pend);
            m_pend_v = 1'b0;
        end
        check_eq("int_after_cs_rise", spi_int, exp_int());
    endtask

    task automatic send_cmd(input logic rw, input logic mb, input logic [5:0] a);
        logic [7:0] rx, oem;
        xfer_bits({rw, mb, a}, 8, rx, oem);
        check_eq("oe_cmd_phase", oem, 8'h00);
        m_rw   = rw;
        m_mb   = mb;
        m_addr = a;
        m_act  = 1'b1;
    endtask

    task automatic send_data(input logic [7:0] tx);
        logic [7:0] rx, oem;
        xfer_bits(tx, 8, rx, oem);
        if (m_act && m_rw) begin
            check_eq($sformatf("rd_%02h", m_addr), rx, m_read(m_addr));
            check_eq("oe_data_phase", oem, 8'hFF);
            if (m_addr == 6'h37) m_hit = 1'b1;
        end else begin
            check_eq("oe_not_reading", oem, 8'h00);
            if (m_act) m_write(m_addr, tx);
        end
        if (m_act) begin
            if (m_mb) m_addr = m_addr + 6'd1;
            else      m_act  = 1'b0;
        end
    endtask

    task automatic do_read(input logic mb, input logic [5:0] a, input int n);
        cs_low();
        send_cmd(1'b1, mb, a);
        for (int i = 0; i < n; i++) send_data(8'h00);
        cs_high();
    endtask

    task automatic do_write(input logic mb, input logic [5:0] a, input logic [7:0] v, input int n);
        cs_low();
        send_cmd(1'b0, mb, a);
        for (int i = 0; i < n; i++) send_data(v + 8'(i * 37));
        cs_high();
    endtask

    task automatic put_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        sample_x     = x;
        sample_y     = y;
        sample_z     = z;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
        if (spi_cs_n) m_load({z, y, x});
        else begin
            m_pend   = {z, y, x};
            m_pend_v = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rx, oem;
        reset_reset_n = 1'b0;
        spi_cs_n      = 1'b1;
        spi_sclk      = 1'b1;
        spi_sdio_in   = 1'b0;
        sample_x      = '0;
        sample_y      = '0;
        sample_z      = '0;
        sample_valid  = 1'b0;
        m_reset();
        wait_clk(4);
        check_eq("rst_sdio_out", spi_sdio_out, 1'b0);
        check_eq("rst_sdio_oe", spi_sdio_oe, 1'b0);
        check_eq("rst_int", spi_int, 1'b0);
        reset_reset_n = 1'b1;
        wait_clk(4);

        do_read(1'b0, 6'h00, 1);                 // DEVID
        do_read(1'b0, 6'h2C, 1);                 // BW_RATE reset value
        do_write(1'b0, 6'h2E, 8'h80, 1);         // INT_ENABLE
        do_read(1'b0, 6'h2E, 1);
        do_write(1'b0, 6'h00, 8'h12, 1);         // RO, discarded
        do_read(1'b0, 6'h00, 1);

        put_sample(16'h1234, 16'hFFFE, 16'h0100);
        wait_clk(3);
        check_eq("int_after_sample", spi_int, 1'b1);
        do_read(1'b1, 6'h32, 6);                 // 34 12 FE FF 00 01, then int clears
        check_eq("int_cleared", spi_int, 1'b0);

        // Sample mid-burst: burst keeps old data, new data appears after CS rise.
        put_sample(16'h1111, 16'h2222, 16'h3333);
        cs_low();
        send_cmd(1'b1, 1'b1, 6'h32);
        for (int i = 0; i < 3; i++) send_data(8'h00);
        put_sample(16'hA5A5, 16'h5A5A, 16'hC3C3);
        for (int i = 0; i < 3; i++) send_data(8'h00);
        cs_high();
        check_eq("int_pending_set_wins", spi_int, 1'b1);
        do_read(1'b1, 6'h30, 8);

        // Partial second byte of an MB write is discarded.
        cs_low();
        send_cmd(1'b0, 1'b1, 6'h2D);
        send_data(8'hAA);
        xfer_bits(8'hBB, 4, rx, oem);
        cs_high();
        do_read(1'b1, 6'h2D, 2);

        do_read(1'b1, 6'h3F, 2);                 // wrap 0x3F -> 0x00

        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 4));
            case (op)
                0: do_write(1'b0, 6'($urandom_range(0, 63)), 8'($urandom), 1);
                1: do_write(1'b1, 6'($urandom_range(28, 50)), 8'($urandom),
                            int'($urandom_range(1, 3)));
                2: do_read(1'b0, 6'($urandom_range(0, 63)), 1);
                3: do_read(1'b1, 6'($urandom_range(40, 63)), int'($urandom_range(1, 5)));
                default: begin
                    put_sample(16'($urandom), 16'($urandom), 16'($urandom));
                    wait_clk(3);
                    check_eq("int_rand_sample", spi_int, exp_int());
                end
            endcase
        end

        // Asynchronous reset in the middle of a read data byte.
        cs_low();
        send_cmd(1'b1, 1'b0, 6'h00);
        xfer_bits(8'h00, 3, rx, oem);
        check_eq("oe_mid_read", spi_sdio_oe, 1'b1);
        reset_reset_n = 1'b0;
        #1;
        check_eq("oe_async_reset", spi_sdio_oe, 1'b0);
        check_eq("int_async_reset", spi_int, 1'b0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b1;
        m_reset();
        wait_clk(3);
        reset_reset_n = 1'b1;
        wait_clk(4);
        do_read(1'b0, 6'h2E, 1);
        do_read(1'b0, 6'h2C, 1);
        do_read(1'b1, 6'h30, 8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
